// File: rtl/conv_frame_sched.sv
// Frame sequencer for the 3x3 convolution engine: loads an input frame into
// the engine frame buffer, fires the engine under a watchdog, drains result rows.
module conv_frame_sched #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int PW      = 8,
  parameter int RW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [COLS*PW-1:0]        in_row,
  output logic                      fb_we,
  output logic [$clog2(ROWS)-1:0]   fb_waddr,
  output logic [COLS*PW-1:0]        fb_wdata,
  output logic                      eng_start,
  input  logic                      eng_done,
  output logic [$clog2(ROWS)-1:0]   res_raddr,
  input  logic [(COLS-1)*RW-1:0]    res_row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(COLS-1)*RW-1:0]    out_row,
  output logic                      out_last,
  output logic [15:0]               frame_cnt,
  output logic                      err_timeout,
  input  logic                      err_clr
);

  localparam int AW = $clog2(ROWS);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
  localparam logic [AW-1:0] LAST_OUT = AW'(ROWS - 2);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN} state_t;

  state_t          state;
  logic [AW-1:0]   row_cnt;
  logic [AW-1:0]   out_idx;
  logic [WW-1:0]   wd_cnt;
  logic            in_accept;
  logic            beat;
  logic            wd_expire;

  // Write strobe and result read path are combinational so the frame buffer
  // sees a row in the same cycle it is accepted, and the engine result mux
  // follows out_idx without an extra stage.
  always_comb begin
    in_accept = in_valid && in_ready;
    fb_we     = in_accept;
    fb_waddr  = row_cnt;
    fb_wdata  = in_row;
    res_raddr = out_idx;
    out_row   = res_row;
    out_last  = out_valid && (out_idx == LAST_OUT);
    beat      = out_valid && out_ready;
    wd_expire = (state == WAIT) && !eng_done && (wd_cnt == WD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      row_cnt     <= '0;
      out_idx     <= '0;
      wd_cnt      <= '0;
      in_ready    <= 1'b0;
      eng_start   <= 1'b0;
      out_valid   <= 1'b0;
      frame_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      eng_start <= 1'b0;

      // A watchdog expiry in the same cycle as a clear keeps the flag set.
      if (wd_expire)
        err_timeout <= 1'b1;
      else if (err_clr)
        err_timeout <= 1'b0;

      unique case (state)
        IDLE: begin
          state    <= LOAD;
          in_ready <= 1'b1;
        end

        LOAD: begin
          if (in_accept) begin
            if (row_cnt == LAST_ROW) begin
              row_cnt   <= '0;
              in_ready  <= 1'b0;
              eng_start <= 1'b1;
              state     <= START;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end

        START: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end

        WAIT: begin
          if (eng_done) begin
            out_idx   <= '0;
            out_valid <= 1'b1;
            state     <= DRAIN;
          end else if (wd_cnt == WD_LAST) begin
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        DRAIN: begin
          if (beat) begin
            if (out_idx == LAST_OUT) begin
              out_idx   <= '0;
              out_valid <= 1'b0;
              frame_cnt <= frame_cnt + 16'd1;
              state     <= IDLE;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  a_start_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    eng_start |=> !eng_start);
  a_write_only_in_load: assert property (@(posedge clk) disable iff (!rst_n)
    fb_we |-> state == LOAD);
  a_drain_holds: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_idx)));

endmodule

// File: doc/conv_frame_sched.md
Name: conv_frame_sched

Overview:
Sequencer for the 3x3 fixed-kernel convolution engine. It accepts an 8x8 signed pixel frame row by row over a valid/ready stream and writes it into the engine's frame buffer. It then fires the engine, waits for its completion pulse with a watchdog, and drains the 7x7 result rows to a downstream valid/ready stream. It sits between the pixel source and the output sink and owns all engine start/handshake timing.

Parameters:
ROWS, 8, input frame rows (result has ROWS-1 rows)
COLS, 8, input frame columns (result has COLS-1 columns)
PW, 8, signed pixel width
RW, 8, signed result element width
TIMEOUT, 16, max cycles in WAIT before watchdog fires (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input row valid
in_ready  out  1  input row ready
in_row  in  COLS*PW  one pixel row; column 0 in LSBs
fb_we  out  1  frame-buffer write strobe
fb_waddr  out  clog2(ROWS)  frame-buffer row address
fb_wdata  out  COLS*PW  frame-buffer row data
eng_start  out  1  one-cycle engine start pulse
eng_done  in  1  engine result-valid pulse
res_raddr  out  clog2(ROWS)  engine result row select (combinational read)
res_row  in  (COLS-1)*RW  selected result row
out_valid  out  1  result row valid
out_ready  in  1  downstream ready
out_row  out  (COLS-1)*RW  result row
out_last  out  1  marks result row ROWS-2
frame_cnt  out  16  completed frames, wraps at 2^16
err_timeout  out  1  sticky watchdog flag
err_clr  in  1  clears err_timeout

Behaviour:
- Reset (async assert, sync release): state IDLE. All counters 0. in_ready=0, fb_we=0, eng_start=0, out_valid=0, out_last=0, err_timeout=0, frame_cnt=0, res_raddr=0.
- States: IDLE, LOAD, START, WAIT, DRAIN.
- IDLE: next cycle goes to LOAD. in_ready=0.
- LOAD: in_ready=1.
  - A row is accepted on in_valid&&in_ready. In that same cycle, fb_we=1 (combinational from the handshake), fb_waddr=row_cnt, fb_wdata=in_row.
  - row_cnt then increments.
  - Acceptance of row ROWS-1 → START, row_cnt←0.
  - Rows are never accepted outside LOAD.
- START: eng_start=1 for exactly this one cycle, then → WAIT with wd_cnt←0. in_ready=0.
- WAIT:
  - eng_done=1 → DRAIN with out_idx←0.
  - Otherwise wd_cnt increments.
  - When wd_cnt reaches TIMEOUT-1 without done: set err_timeout, → IDLE. The frame is dropped and frame_cnt is unchanged.
  - If eng_done coincides with the wd_cnt==TIMEOUT-1 cycle, done wins: no error.
- DRAIN:
  - res_raddr=out_idx, out_row=res_row, out_valid=1, out_last=(out_idx==ROWS-2).
  - On out_valid&&out_ready, out_idx increments.
  - On the last beat: → IDLE and frame_cnt increments.
  - Under backpressure, out_row, out_last and res_raddr hold stable.
- eng_done outside WAIT is ignored (no state change, no error).
- err_timeout: sticky until err_clr=1 is sampled. If a set and a clear coincide, the set wins.
- Minimum frame period (no stalls, engine done on the second WAIT cycle): 1 IDLE + ROWS LOAD + 1 START + 2 WAIT + (ROWS-1) DRAIN = 19 cycles at defaults.
- Arithmetic: counters are unsigned. The block does not touch pixel or result values; they pass through bit-exact.
- Reset mid-operation: returns to IDLE immediately. A partial frame is discarded. eng_start, fb_we and out_valid deassert asynchronously.

Test Plan:
- Nominal frame: 8 rows (row r, pixels all = r+1), in_valid held high, out_ready high, eng_done 2 cycles after eng_start → 8 fb writes at addresses 0..7 with matching data; one eng_start pulse; 7 out beats at res_raddr 0..6; out_last only on beat 7; frame_cnt=1.
- Input gaps: in_valid toggled 1/0 each cycle → exactly 8 writes, addresses contiguous, eng_start only after the 8th acceptance.
- Backpressure: out_ready low for 3 cycles at beat 3 → out_row/res_raddr=3 held stable, no beat lost or duplicated, 7 total beats.
- Watchdog: eng_done never asserted → err_timeout=1 exactly TIMEOUT=16 cycles after entering WAIT, state returns to LOAD, frame_cnt unchanged. Then pulse err_clr → err_timeout=0.
- Spurious done and tie: eng_done pulsed during LOAD → ignored. eng_done on the 16th WAIT cycle → DRAIN entered, err_timeout stays 0.
- Async reset during DRAIN beat 4 → all outputs at reset values the same cycle. A following full frame completes normally and frame_cnt=1 relative to reset.
